pwm_capture: RTL

//  Measures an external PWM waveform: period and high time, in prescaled clk ticks.
//  It is the inverse of the PWM generator path.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_in_sync.sv | 33 +++
 rtl/pwm_capture.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and FSM state encoding for the PWM capture path.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W = 16;
    localparam int unsigned PWM_PS_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } pwm_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizer for the asynchronous PWM input plus edge detection.
module pwm_in_sync
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pwm,
    output logic o_pwm_s,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pwm_d;

    // Shift the raw input through the synchronizer chain and keep a delayed copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_pwm_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pwm};
            r_pwm_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pwm_s = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_pwm_s & ~r_pwm_d;
    assign o_fall  = ~o_pwm_s & r_pwm_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM waveform in prescaled clk ticks.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH       = PWM_CNT_W,
    parameter int unsigned PS_WIDTH    = PWM_PS_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    input  logic                en,
    input  logic                clear,
    input  logic [PS_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]    period_val,
    output logic [WIDTH-1:0]    duty_val,
    output logic                meas_valid,
    output logic                ovf
);

    pwm_state_e          r_state;
    pwm_state_e          w_state_d;

    logic [PS_WIDTH-1:0] r_ps_cnt;
    logic [PS_WIDTH-1:0] r_ps_lat;
    logic [WIDTH-1:0]    r_per_cnt;
    logic [WIDTH-1:0]    r_hi_cnt;
    logic [WIDTH-1:0]    r_hi_sh;
    logic [WIDTH-1:0]    r_period;
    logic [WIDTH-1:0]    r_duty;
    logic                r_valid;
    logic                r_ovf;

    logic                w_pwm_s;
    logic                w_rise;
    logic                w_fall;
    logic                w_tick;
    logic                w_ps_zero;
    logic                w_counting;
    logic                w_start;
    logic                w_strobe;
    logic                w_latch_hi;
    logic                w_ovf_hit;

    pwm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_pwm   (pwm_in),
        .o_pwm_s (w_pwm_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Tick on the last cycle of each (prescale+1)-cycle group within the window.
    assign w_tick     = (r_ps_cnt == r_ps_lat);
    assign w_ps_zero  = (prescale == '0);
    assign w_counting = (r_state == S_HIGH) || (r_state == S_LOW);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic; disable dominates clear, clear dominates edges and overflow.
    always_comb begin
        w_state_d = r_state;
        if (!en) begin
            w_state_d = S_IDLE;
        end else if (clear) begin
            w_state_d = S_ARM;
        end else begin
            case (r_state)
                S_IDLE: w_state_d = S_ARM;
                S_ARM:  if (w_rise) w_state_d = S_HIGH;
                S_HIGH: begin
                    if (w_ovf_hit) begin
                        w_state_d = S_ARM;
                    end else if (w_fall) begin
                        w_state_d = S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_rise) begin
                        w_state_d = S_HIGH;
                    end else if (w_ovf_hit) begin
                        w_state_d = S_ARM;
                    end
                end
                default: w_state_d = S_IDLE;
            endcase
        end
    end

    // Per-state event decode driving the datapath.
    always_comb begin
        w_start    = 1'b0;
        w_strobe   = 1'b0;
        w_latch_hi = 1'b0;
        w_ovf_hit  = 1'b0;
        if (en && !clear) begin
            case (r_state)
                S_ARM: w_start = w_rise;
                S_HIGH: begin
                    w_ovf_hit  = w_tick && (r_per_cnt == '1);
                    w_latch_hi = w_fall && !w_ovf_hit;
                end
                S_LOW: begin
                    // The rise cycle belongs to the next window, so it cannot overflow this one.
                    w_start   = w_rise;
                    w_strobe  = w_rise;
                    w_ovf_hit = !w_rise && w_tick && (r_per_cnt == '1);
                end
                default: ;
            endcase
        end
    end

    // Prescaler, measurement counters, high-time shadow and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps_cnt  <= '0;
            r_ps_lat  <= '0;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_hi_sh   <= '0;
            r_period  <= '0;
            r_duty    <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (clear || !en) begin
                r_ps_cnt  <= '0;
                r_ps_lat  <= '0;
                r_per_cnt <= '0;
                r_hi_cnt  <= '0;
                r_hi_sh   <= '0;
                if (clear) begin
                    r_period <= '0;
                    r_duty   <= '0;
                    r_ovf    <= 1'b0;
                end
            end else if (w_start) begin
                if (w_strobe) begin
                    r_period <= r_per_cnt;
                    r_duty   <= r_hi_sh;
                    r_valid  <= 1'b1;
                    r_ovf    <= 1'b0;
                end
                // The rise cycle is k=0 of the new window and is itself high.
                r_ps_lat  <= prescale;
                r_ps_cnt  <= {{(PS_WIDTH-1){1'b0}}, ~w_ps_zero};
                r_per_cnt <= {{(WIDTH-1){1'b0}}, w_ps_zero};
                r_hi_cnt  <= {{(WIDTH-1){1'b0}}, w_ps_zero};
                r_hi_sh   <= '0;
            end else if (w_ovf_hit) begin
                r_ovf     <= 1'b1;
                r_ps_cnt  <= '0;
                r_ps_lat  <= '0;
                r_per_cnt <= '0;
                r_hi_cnt  <= '0;
                r_hi_sh   <= '0;
            end else if (w_counting) begin
                if (w_tick) begin
                    r_ps_cnt  <= '0;
                    r_per_cnt <= r_per_cnt + 1'b1;
                    if (w_pwm_s) begin
                        r_hi_cnt <= r_hi_cnt + 1'b1;
                    end
                end else begin
                    r_ps_cnt <= r_ps_cnt + 1'b1;
                end
                if (w_latch_hi) begin
                    r_hi_sh <= r_hi_cnt;
                end
            end
        end
    end

    assign period_val = r_period;
    assign duty_val   = r_duty;
    assign meas_valid = r_valid;
    assign ovf        = r_ovf;

endmodule
